// File: rtl/stopwatch_timebase_counter.sv
// Stopwatch datapath: 10 ms timebase prescaler, 4-digit BCD SS.hh counter
// and active-low 7-segment decode for the display multiplexer.
module stopwatch_timebase_counter #(
   parameter int TICK_DIV = 1000000,
   parameter int PRESC_W  = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        stop,
   output logic [6:0]  seg0,
   output logic [6:0]  seg1,
   output logic [6:0]  seg2,
   output logic [6:0]  seg3,
   output logic [15:0] bcd,
   output logic        tick,
   output logic        wrap
);

   localparam logic [PRESC_W-1:0] TERM = PRESC_W'(TICK_DIV - 1);

   logic [PRESC_W-1:0] presc;
   logic [3:0]         d0, d1, d2, d3;
   logic [3:0]         n0, n1, n2, n3;
   logic               c0, c1, c2, c3;
   logic               term;

   assign term = (presc == TERM);

   // Ripple-carry BCD increment; c3 marks the 99.99 -> 00.00 rollover
   always_comb begin
      c0 = (d0 == 4'd9);
      c1 = c0 && (d1 == 4'd9);
      c2 = c1 && (d2 == 4'd9);
      c3 = c2 && (d3 == 4'd9);
      n0 = c0 ? 4'd0 : d0 + 4'd1;
      n1 = d1;
      n2 = d2;
      n3 = d3;
      if (c0) n1 = c1 ? 4'd0 : d1 + 4'd1;
      if (c1) n2 = c2 ? 4'd0 : d2 + 4'd1;
      if (c2) n3 = c3 ? 4'd0 : d3 + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         presc <= '0;
         d0    <= 4'd0;
         d1    <= 4'd0;
         d2    <= 4'd0;
         d3    <= 4'd0;
         tick  <= 1'b0;
         wrap  <= 1'b0;
      end else if (stop) begin
         tick  <= 1'b0;
         wrap  <= 1'b0;
      end else if (term) begin
         presc <= '0;
         d0    <= n0;
         d1    <= n1;
         d2    <= n2;
         d3    <= n3;
         tick  <= 1'b1;
         wrap  <= c3;
      end else begin
         presc <= presc + PRESC_W'(1);
         tick  <= 1'b0;
         wrap  <= 1'b0;
      end
   end

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   assign seg0 = seg7(d0);
   assign seg1 = seg7(d1);
   assign seg2 = seg7(d2);
   assign seg3 = seg7(d3);
   assign bcd  = {d3, d2, d1, d0};

endmodule

// File: tb/tb_stopwatch_timebase_counter.sv
// Bench for stopwatch_timebase_counter: directed scenarios plus random
// reset/clr/stop traffic against a run-cycle-count reference model.
module tb_stopwatch_timebase_counter;

   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        reset, clr, stop;
   logic [6:0]  seg0, seg1, seg2, seg3;
   logic [15:0] bcd;
   logic        tick, wrap;

   int n_checks = 0;
   int n_fail   = 0;
   int runs     = 0;
   int tick_cnt = 0;
   logic e_tick, e_wrap;
   logic [15:0] eb;

   logic [6:0] segtab [0:15] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
      7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
   };

   stopwatch_timebase_counter #(.TICK_DIV(TD), .PRESC_W(3)) dut (
      .clk(clk), .reset(reset), .clr(clr), .stop(stop),
      .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
      .bcd(bcd), .tick(tick), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected display: total run cycles since clear, in whole ticks, mod 10000
   function automatic logic [15:0] exp_bcd();
      int c;
      c = (runs / TD) % 10000;
      return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
   endfunction

   task automatic cyc(input logic r, input logic c, input logic s);
      reset = r;
      clr   = c;
      stop  = s;
      @(posedge clk);
      if (r || c) begin
         runs   = 0;
         e_tick = 1'b0;
         e_wrap = 1'b0;
      end else if (s) begin
         e_tick = 1'b0;
         e_wrap = 1'b0;
      end else begin
         runs++;
         e_tick = (runs % TD == 0);
         e_wrap = e_tick && ((runs / TD) % 10000 == 0);
      end
      #1;
      if (tick) tick_cnt++;
      eb = exp_bcd();
      check("bcd", 32'(bcd), 32'(eb));
      check("tick", 32'(tick), 32'(e_tick));
      check("wrap", 32'(wrap), 32'(e_wrap));
      check("seg0", 32'(seg0), 32'(segtab[eb[3:0]]));
      check("seg1", 32'(seg1), 32'(segtab[eb[7:4]]));
      check("seg2", 32'(seg2), 32'(segtab[eb[11:8]]));
      check("seg3", 32'(seg3), 32'(segtab[eb[15:12]]));
   endtask

   task automatic run_n(input int n, input logic s);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, s);
   endtask

   initial begin
      reset = 1'b1;
      clr   = 1'b0;
      stop  = 1'b0;

      // 1: reset then 40 run cycles
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      check("rst_bcd", 32'(bcd), 32'h0);
      check("rst_seg0", 32'(seg0), 32'b1000000);
      tick_cnt = 0;
      run_n(40, 1'b0);
      check("t1_bcd", 32'(bcd), 32'h0010);
      check("t1_ticks", 32'(tick_cnt), 32'd10);
      check("t1_seg1", 32'(seg1), 32'b1111001);

      // 2: d0 -> d1 carry
      cyc(1'b0, 1'b1, 1'b0);
      run_n(36, 1'b0);
      check("t2_pre", 32'(seg0), 32'b0010000);
      run_n(4, 1'b0);
      check("t2_bcd", 32'(bcd), 32'h0010);
      check("t2_tick", 32'(tick), 32'd1);

      // 3: full-scale rollover
      cyc(1'b0, 1'b1, 1'b0);
      run_n(39996, 1'b0);
      check("t3_max", 32'(bcd), 32'h9999);
      run_n(4, 1'b0);
      check("t3_bcd", 32'(bcd), 32'h0);
      check("t3_wrap", 32'(wrap), 32'd1);
      run_n(1, 1'b0);
      check("t3_wrap1", 32'(wrap), 32'd0);

      // 4: pause keeps sub-tick phase
      cyc(1'b0, 1'b1, 1'b0);
      run_n(6, 1'b0);
      tick_cnt = 0;
      run_n(20, 1'b1);
      check("t4_stop", 32'(tick_cnt), 32'd0);
      run_n(2, 1'b0);
      check("t4_bcd", 32'(bcd), 32'h0002);

      // 5: clr+stop together, then stop alone
      cyc(1'b0, 1'b1, 1'b0);
      run_n(20, 1'b0);
      check("t5_pre", 32'(bcd), 32'h0005);
      cyc(1'b0, 1'b1, 1'b1);
      tick_cnt = 0;
      run_n(8, 1'b1);
      check("t5_bcd", 32'(bcd), 32'h0);
      check("t5_notick", 32'(tick_cnt), 32'd0);
      run_n(3, 1'b0);
      check("t5_early", 32'(tick_cnt), 32'd0);
      run_n(1, 1'b0);
      check("t5_tick", 32'(tick), 32'd1);

      // 6: clr on terminal count, reset mid-count
      cyc(1'b0, 1'b1, 1'b0);
      run_n(3, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      check("t6_clr_tick", 32'(tick), 32'd0);
      check("t6_clr_bcd", 32'(bcd), 32'h0);
      run_n(6, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      check("t6_rst_bcd", 32'(bcd), 32'h0);
      run_n(4, 1'b0);
      check("t6_rst_tick", 32'(tick), 32'd1);

      // Random control traffic
      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom % 300) == 0, ($urandom % 60) == 0,
             ($urandom % 4) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
